core_wb_wbu_mc: RTL and testbench

- Parametrised multi-source write-back stage for the core pipeline; sits between the MEM stage and the integer register-file write port.
- Registers one instruction per handshake and selects its result from NSRC execution sources.
- Extracts and sign/zero-extends load data from the LSU source.
- Drives the RF write, WB-stage forwarding and a retired-instruction counter; honours back-pressure from a shared RF write port.

---
 rtl/core_wb_pkg.sv | 20 ++
 rtl/core_wb_ldfmt.sv | 44 ++++
 rtl/core_wb_wbu_mc.sv | 169 ++++++++++++++++
 tb/tb_core_wb_wbu_mc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_wb_pkg.sv
// Shared encodings and width helpers for the write-back unit.
package core_wb_pkg;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned off_w(input int unsigned xlen);
        return (xlen <= 8) ? 1 : $clog2(xlen / 8);
    endfunction

    localparam int unsigned SEL_W = sel_w(4);
    localparam int unsigned OFF_W = off_w(32);

endpackage

// File: rtl/core_wb_ldfmt.sv
// Load data formatter: shift by byte offset, extract by size, extend.
module core_wb_ldfmt
    import core_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]         raw_i,
    input  logic [1:0]              size_i,
    input  logic                    uns_i,
    input  logic [off_w(XLEN)-1:0]  off_i,
    output logic [XLEN-1:0]         data_o
);

    localparam logic IS64 = (XLEN > 32);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ext_w;

    assign sh = raw_i >> {off_i, 3'b000};

    generate
        if (XLEN > 32) begin : g_w64
            assign ext_w = {{(XLEN-32){~uns_i & sh[31]}}, sh[31:0]};
        end else begin : g_w32
            assign ext_w = sh;
        end
    endgenerate

    // A dword request on a 32-bit datapath falls through to word.
    always_comb begin
        data_o = ext_w;
        unique case (1'b1)
            (size_i == LD_B):
                data_o = {{(XLEN-8){~uns_i & sh[7]}}, sh[7:0]};
            (size_i == LD_H):
                data_o = {{(XLEN-16){~uns_i & sh[15]}}, sh[15:0]};
            (size_i == LD_D) && IS64:
                data_o = sh;
            default:
                data_o = ext_w;
        endcase
    end

endmodule

// File: rtl/core_wb_wbu_mc.sv
// Multi-source write-back stage with RF write, forwarding and retire count.
// Optional difftest commit ports enabled by CORE_WB_DIFFTEST_EN.
module core_wb_wbu_mc
    import core_wb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned NSRC    = 4,
    parameter int unsigned LSU_SRC = 1,
    parameter int unsigned RET_W   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    input  logic [RFIDX_W-1:0]         i_rd_idx,
    input  logic                       i_rd_wen,
    input  logic [sel_w(NSRC)-1:0]     i_src_sel,
    input  logic [NSRC*XLEN-1:0]       i_results,
    input  logic [1:0]                 i_ld_size,
    input  logic                       i_ld_unsigned,
    input  logic [off_w(XLEN)-1:0]     i_ld_offset,
    output logic                       wb_en,
    output logic [RFIDX_W-1:0]         wb_idx,
    output logic [XLEN-1:0]            wb_data,
    output logic [RFIDX_W-1:0]         rd_idx_wb_forward,
    output logic                       rd_wen_wb_forward,
    output logic [XLEN-1:0]            rd_dat_wb_forward,
    output logic [RET_W-1:0]           retire_cnt
`ifdef CORE_WB_DIFFTEST_EN
    ,
    input  logic [XLEN-1:0]            i_pc,
    input  logic [31:0]                i_inst,
    output logic                       difftest_commit,
    output logic [XLEN-1:0]            difftest_pc,
    output logic [31:0]                difftest_inst
`endif
);

    localparam int unsigned SW = sel_w(NSRC);
    localparam int unsigned OW = off_w(XLEN);

    logic               valid_q,  valid_d;
    logic [RFIDX_W-1:0] rd_idx_q, rd_idx_d;
    logic               rd_wen_q, rd_wen_d;
    logic [SW-1:0]      sel_q,    sel_d;
    logic [XLEN-1:0]    res_q,    res_d;
    logic [1:0]         size_q,   size_d;
    logic               uns_q,    uns_d;
    logic [OW-1:0]      off_q,    off_d;
    logic [RET_W-1:0]   ret_q,    ret_d;

    logic            load;
    logic            retire;
    logic [XLEN-1:0] sel_res;
    logic [XLEN-1:0] fmt_data;
    logic            wr_ok;

    assign ready_in = ~valid_q | ready_out;
    assign load     = valid_in & ready_in;
    assign retire   = valid_q & ready_out;

    // Out-of-range selectors leave sel_res at zero.
    always_comb begin
        sel_res = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (i_src_sel == SW'(k)) begin
                sel_res = i_results[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        rd_idx_d = rd_idx_q;
        rd_wen_d = rd_wen_q;
        sel_d    = sel_q;
        res_d    = res_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        ret_d    = ret_q;
        if (retire) begin
            valid_d = 1'b0;
            ret_d   = ret_q + RET_W'(1);
        end
        if (load) begin
            valid_d  = 1'b1;
            rd_idx_d = i_rd_idx;
            rd_wen_d = i_rd_wen;
            sel_d    = i_src_sel;
            res_d    = sel_res;
            size_d   = i_ld_size;
            uns_d    = i_ld_unsigned;
            off_d    = i_ld_offset;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rd_idx_q <= '0;
            rd_wen_q <= 1'b0;
            sel_q    <= '0;
            res_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            ret_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_idx_q <= rd_idx_d;
            rd_wen_q <= rd_wen_d;
            sel_q    <= sel_d;
            res_q    <= res_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            ret_q    <= ret_d;
        end
    end

    core_wb_ldfmt #(
        .XLEN   (XLEN)
    ) u_ldfmt (
        .raw_i  (res_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .off_i  (off_q),
        .data_o (fmt_data)
    );

    assign wr_ok   = valid_q & rd_wen_q & (rd_idx_q != '0);
    assign wb_data = (sel_q == SW'(LSU_SRC)) ? fmt_data : res_q;
    assign wb_idx  = rd_idx_q;
    assign wb_en   = wr_ok & ready_out;

    assign rd_idx_wb_forward = rd_idx_q;
    assign rd_wen_wb_forward = wr_ok;
    assign rd_dat_wb_forward = wb_data;

    assign valid_out  = valid_q;
    assign retire_cnt = ret_q;

`ifdef CORE_WB_DIFFTEST_EN
    logic [XLEN-1:0] pc_q,   pc_d;
    logic [31:0]     inst_q, inst_d;

    assign pc_d   = load ? i_pc   : pc_q;
    assign inst_d = load ? i_inst : inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign difftest_commit = retire;
    assign difftest_pc     = pc_q;
    assign difftest_inst   = inst_q;
`endif

endmodule

// File: tb/tb_core_wb_wbu_mc.sv
// Bench for core_wb_wbu_mc: a default instance plus a NSRC=3/RET_W=4 twin.
module tb_core_wb_wbu_mc;
    import core_wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready_out;
    logic [4:0]   i_rd_idx;
    logic         i_rd_wen;
    logic [SEL_W-1:0] i_src_sel;
    logic [127:0] i_results;
    logic [1:0]   i_ld_size;
    logic         i_ld_unsigned;
    logic [OFF_W-1:0] i_ld_offset;

    logic         ready_in, valid_out, wb_en, fwd_v;
    logic [4:0]   wb_idx, fwd_idx;
    logic [31:0]  wb_data, fwd_dat;
    logic [63:0]  retire_cnt;

    logic         ready_in_b, valid_out_b, wb_en_b, fwd_v_b;
    logic [4:0]   wb_idx_b, fwd_idx_b;
    logic [31:0]  wb_data_b, fwd_dat_b;
    logic [3:0]   retire_cnt_b;

`ifdef CORE_WB_DIFFTEST_EN
    logic [31:0]  i_pc, i_inst;
    logic         dt_c, dt_c_b;
    logic [31:0]  dt_pc, dt_inst, dt_pc_b, dt_inst_b;
    assign i_pc   = 32'h0;
    assign i_inst = 32'h0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_wb_wbu_mc u_dut (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .ready_out         (ready_out),
        .i_rd_idx          (i_rd_idx),
        .i_rd_wen          (i_rd_wen),
        .i_src_sel         (i_src_sel),
        .i_results         (i_results),
        .i_ld_size         (i_ld_size),
        .i_ld_unsigned     (i_ld_unsigned),
        .i_ld_offset       (i_ld_offset),
        .wb_en             (wb_en),
        .wb_idx            (wb_idx),
        .wb_data           (wb_data),
        .rd_idx_wb_forward (fwd_idx),
        .rd_wen_wb_forward (fwd_v),
        .rd_dat_wb_forward (fwd_dat),
        .retire_cnt        (retire_cnt)
`ifdef CORE_WB_DIFFTEST_EN
        ,
        .i_pc              (i_pc),
        .i_inst            (i_inst),
        .difftest_commit   (dt_c),
        .difftest_pc       (dt_pc),
        .difftest_inst     (dt_inst)
`endif
    );

    core_wb_wbu_mc #(
        .NSRC  (3),
        .RET_W (4)
    ) u_dut_b (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .ready_in          (ready_in_b),
        .valid_out         (valid_out_b),
        .ready_out         (ready_out),
        .i_rd_idx          (i_rd_idx),
        .i_rd_wen          (i_rd_wen),
        .i_src_sel         (i_src_sel),
        .i_results         (i_results[95:0]),
        .i_ld_size         (i_ld_size),
        .i_ld_unsigned     (i_ld_unsigned),
        .i_ld_offset       (i_ld_offset),
        .wb_en             (wb_en_b),
        .wb_idx            (wb_idx_b),
        .wb_data           (wb_data_b),
        .rd_idx_wb_forward (fwd_idx_b),
        .rd_wen_wb_forward (fwd_v_b),
        .rd_dat_wb_forward (fwd_dat_b),
        .retire_cnt        (retire_cnt_b)
`ifdef CORE_WB_DIFFTEST_EN
        ,
        .i_pc              (i_pc),
        .i_inst            (i_inst),
        .difftest_commit   (dt_c_b),
        .difftest_pc       (dt_pc_b),
        .difftest_inst     (dt_inst_b)
`endif
    );

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp;
        logic [31:0] exp_b;
        logic        en;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{2'd1, LD_B, 1'b0, 2'd1, 5'd10, 1'b1,
                   32'h0000007F, 32'h0000007F, 1'b1};
        tv[1]  = '{2'd1, LD_B, 1'b0, 2'd2, 5'd11, 1'b1,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        tv[2]  = '{2'd1, LD_H, 1'b1, 2'd2, 5'd12, 1'b1,
                   32'h000080FF, 32'h000080FF, 1'b1};
        tv[3]  = '{2'd1, LD_H, 1'b0, 2'd2, 5'd13, 1'b1,
                   32'hFFFF80FF, 32'hFFFF80FF, 1'b1};
        tv[4]  = '{2'd1, LD_W, 1'b0, 2'd0, 5'd14, 1'b1,
                   32'h80FF7F01, 32'h80FF7F01, 1'b1};
        tv[5]  = '{2'd1, LD_B, 1'b1, 2'd0, 5'd15, 1'b1,
                   32'h00000001, 32'h00000001, 1'b1};
        tv[6]  = '{2'd1, LD_B, 1'b0, 2'd3, 5'd16, 1'b1,
                   32'hFFFFFF80, 32'hFFFFFF80, 1'b1};
        tv[7]  = '{2'd0, LD_B, 1'b0, 2'd1, 5'd17, 1'b1,
                   32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        tv[8]  = '{2'd1, LD_D, 1'b0, 2'd0, 5'd18, 1'b1,
                   32'h80FF7F01, 32'h80FF7F01, 1'b1};
        tv[9]  = '{2'd2, LD_W, 1'b0, 2'd0, 5'd0,  1'b1,
                   32'h11112222, 32'h11112222, 1'b0};
        tv[10] = '{2'd2, LD_W, 1'b0, 2'd0, 5'd3,  1'b0,
                   32'h11112222, 32'h11112222, 1'b0};
        tv[11] = '{2'd3, LD_W, 1'b0, 2'd0, 5'd4,  1'b1,
                   32'hCAFEF00D, 32'h00000000, 1'b1};

        i_results = {32'hCAFEF00D, 32'h11112222,
                     32'h80FF7F01, 32'hDEADBEEF};
        rst           = 1'b1;
        valid_in      = 1'b1;
        ready_out     = 1'b1;
        i_rd_idx      = 5'd5;
        i_rd_wen      = 1'b1;
        i_src_sel     = 2'd0;
        i_ld_size     = LD_W;
        i_ld_unsigned = 1'b0;
        i_ld_offset   = 2'd0;

        #1;
        chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
        step();
        step();
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
        chk("rst_fwd_v", {63'd0, fwd_v}, 64'd0);

        i_results[31:0] = 32'h00001234;
        rst = 1'b0;
        step();
        valid_in = 1'b0;
        chk("first_wb_en", {63'd0, wb_en}, 64'd1);
        chk("first_wb_idx", {59'd0, wb_idx}, 64'd5);
        chk("first_wb_data", {32'd0, wb_data}, 64'h1234);
        chk("first_retire_pre", retire_cnt, 64'd0);
        step();
        chk("first_retire", retire_cnt, 64'd1);
        chk("first_empty", {63'd0, valid_out}, 64'd0);
        i_results[31:0] = 32'hDEADBEEF;

        for (int i = 0; i < 12; i++) begin
            i_src_sel     = tv[i].sel;
            i_ld_size     = tv[i].sz;
            i_ld_unsigned = tv[i].uns;
            i_ld_offset   = tv[i].off;
            i_rd_idx      = tv[i].rd;
            i_rd_wen      = tv[i].wen;
            valid_in      = 1'b1;
            step();
            valid_in = 1'b0;
            chk($sformatf("v%0d_data", i), {32'd0, wb_data},
                {32'd0, tv[i].exp});
            chk($sformatf("v%0d_data_b", i), {32'd0, wb_data_b},
                {32'd0, tv[i].exp_b});
            chk($sformatf("v%0d_en", i), {63'd0, wb_en},
                {63'd0, tv[i].en});
            chk($sformatf("v%0d_fwd_v", i), {63'd0, fwd_v},
                {63'd0, tv[i].en});
            chk($sformatf("v%0d_idx", i), {59'd0, wb_idx},
                {59'd0, tv[i].rd});
            chk($sformatf("v%0d_fwd_dat", i), {32'd0, fwd_dat},
                {32'd0, tv[i].exp});
        end
        step();
        chk("tbl_retire", retire_cnt, 64'd13);

        i_src_sel     = 2'd0;
        i_ld_size     = LD_W;
        i_ld_unsigned = 1'b0;
        i_ld_offset   = 2'd0;
        i_rd_idx      = 5'd7;
        i_rd_wen      = 1'b1;
        valid_in      = 1'b1;
        step();
        ready_out = 1'b0;
        i_rd_idx  = 5'd9;
        i_src_sel = 2'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp%0d_ready_in", c), {63'd0, ready_in}, 64'd0);
            chk($sformatf("bp%0d_wb_en", c), {63'd0, wb_en}, 64'd0);
            chk($sformatf("bp%0d_idx", c), {59'd0, wb_idx}, 64'd7);
            chk($sformatf("bp%0d_data", c), {32'd0, wb_data},
                64'hDEADBEEF);
            chk($sformatf("bp%0d_fwd_v", c), {63'd0, fwd_v}, 64'd1);
            chk($sformatf("bp%0d_fwd_idx", c), {59'd0, fwd_idx}, 64'd7);
            if (c < 3) step();
        end
        chk("bp_retire_hold", retire_cnt, 64'd13);
        ready_out = 1'b1;
        #1;
        chk("bp_rel_wb_en", {63'd0, wb_en}, 64'd1);
        chk("bp_rel_ready_in", {63'd0, ready_in}, 64'd1);
        step();
        valid_in = 1'b0;
        chk("bp_next_idx", {59'd0, wb_idx}, 64'd9);
        chk("bp_next_data", {32'd0, wb_data}, 64'h11112222);
        chk("bp_next_valid", {63'd0, valid_out}, 64'd1);
        chk("bp_retire_one", retire_cnt, 64'd14);
        step();
        chk("bp_retire", retire_cnt, 64'd15);

        i_src_sel = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            i_rd_idx = 5'(i);
            valid_in = 1'b1;
            step();
            chk($sformatf("b2b%0d_en", i), {63'd0, wb_en}, 64'd1);
            chk($sformatf("b2b%0d_idx", i), {59'd0, wb_idx}, 64'(i));
            chk($sformatf("b2b%0d_ret", i), retire_cnt, 64'(15 + i - 1));
            chk($sformatf("b2b%0d_ret_b", i), {60'd0, retire_cnt_b},
                64'((15 + i - 1) % 16));
        end
        valid_in = 1'b0;
        step();
        chk("b2b_empty", {63'd0, valid_out}, 64'd0);
        chk("b2b_retire", retire_cnt, 64'd23);
        chk("b2b_retire_b", {60'd0, retire_cnt_b}, 64'd7);

        i_rd_idx = 5'd6;
        valid_in = 1'b1;
        step();
        chk("mid_loaded", {63'd0, wb_en}, 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("mid_rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("mid_rst_ret", retire_cnt, 64'd0);
        step();
        chk("mid_rst_hold", {63'd0, wb_en}, 64'd0);
        rst      = 1'b0;
        valid_in = 1'b0;
        step();
        chk("post_rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("post_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("post_rst_ret", retire_cnt, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
